// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction ROM and
// presents one instruction per cycle to decode, with stall, absolute redirect and halt.
module fetch_unit #(
    parameter int             D          = 10,
    parameter int             W          = 9,
    parameter int             CW         = 16,
    parameter logic [W-1:0]   HALT_INSTR = 9'h1FF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          absjump_en,
    input  logic [D-1:0]  target,
    output logic [D-1:0]  rom_addr,
    input  logic [W-1:0]  rom_data,
    output logic [W-1:0]  instr,
    output logic          instr_valid,
    output logic [D-1:0]  prog_ctr,
    output logic [CW-1:0] instr_count,
    output logic          done
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  fetch_pc_q, fetch_pc_d;
    logic [D-1:0]  req_pc_q, req_pc_d;
    logic          req_v_q, req_v_d;
    logic          done_q, done_d;
    logic [CW-1:0] count_q, count_d;

    logic accept;
    logic is_halt;

    assign instr_valid = req_v_q & (state_q == RUN);
    assign is_halt     = (rom_data == HALT_INSTR);
    assign accept      = instr_valid & ~stall;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: HALT is left only through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && is_halt) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // Output logic
    always_comb begin
        instr    = instr_valid ? rom_data : '0;
        prog_ctr = req_pc_q;
        // Replaying the in-flight address keeps rom_data stable for the whole stall
        rom_addr = (stall && req_v_q) ? req_pc_q : fetch_pc_q;
        instr_count = count_q;
        done        = done_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req_v_d    = req_v_q;
        done_d     = done_q;
        count_d    = count_q;

        if (accept && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end

        if ((state_q == RUN) && !stall) begin
            if (accept && is_halt) begin
                // Halt wins over a redirect; fetch_pc freezes so rom_addr stays put
                req_v_d = 1'b0;
                done_d  = 1'b1;
            end else if (accept && absjump_en) begin
                // Word fetched this cycle is wrong-path: drop it, one bubble follows
                fetch_pc_d = target;
                req_v_d    = 1'b0;
            end else begin
                req_pc_d   = fetch_pc_q;
                req_v_d    = 1'b1;
                fetch_pc_d = fetch_pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= '0;
            req_pc_q   <= '0;
            req_v_q    <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            req_v_q    <= req_v_d;
            done_q     <= done_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural 1-cycle ROM, linear scenario sequence,
// immediate-assertion checks against hand-computed values.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        absjump_en;
    logic [9:0]  target;
    logic [9:0]  rom_addr;
    logic [8:0]  rom_data;
    logic [8:0]  instr;
    logic        instr_valid;
    logic [9:0]  prog_ctr;
    logic [15:0] instr_count;
    logic        done;

    logic [8:0]  mem [0:1023];

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .absjump_en  (absjump_en),
        .target      (target),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .prog_ctr    (prog_ctr),
        .instr_count (instr_count),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_valid(input string tag, input logic [9:0] pc,
                                input logic [8:0] ins, input logic [15:0] cnt);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_pc"},    32'(prog_ctr),    32'(pc));
        chk({tag, "_instr"}, 32'(instr),       32'(ins));
        chk({tag, "_count"}, 32'(instr_count), 32'(cnt));
        $display("step %s: valid=%0b pc=%h instr=%h count=%0d done=%0b",
                 tag, instr_valid, prog_ctr, instr, instr_count, done);
    endtask

    task automatic expect_bubble(input string tag, input logic [9:0] ra, input logic [15:0] cnt);
        chk({tag, "_valid"},    32'(instr_valid), 32'd0);
        chk({tag, "_instr"},    32'(instr),       32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr),    32'(ra));
        chk({tag, "_count"},    32'(instr_count), 32'(cnt));
        $display("step %s: valid=%0b rom_addr=%h count=%0d done=%0b",
                 tag, instr_valid, rom_addr, instr_count, done);
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        absjump_en = 1'b0;
        target     = '0;
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] a;
            a      = 10'(i);
            mem[i] = a[8:0] ^ 9'h0A5;
        end

        #1;
        chk("rst_valid",    32'(instr_valid), 32'd0);
        chk("rst_instr",    32'(instr),       32'd0);
        chk("rst_pc",       32'(prog_ctr),    32'd0);
        chk("rst_rom_addr", 32'(rom_addr),    32'd0);
        chk("rst_count",    32'(instr_count), 32'd0);
        chk("rst_done",     32'(done),        32'd0);
        step();
        step();

        // Scenario 1: reset release, free-running fetch
        reset = 1'b0;
        #1;
        expect_bubble("s1_c0", 10'h000, 16'd0);
        chk("s1_done", 32'(done), 32'd0);
        step(); expect_valid("s1_p0", 10'h000, 9'h0A5, 16'd0);
        step(); expect_valid("s1_p1", 10'h001, 9'h0A4, 16'd1);
        step();

        // Scenario 2: three stall cycles at pc 2
        stall = 1'b1;
        #1;
        expect_valid("s2_st0", 10'h002, 9'h0A7, 16'd2);
        chk("s2_st0_rom_addr", 32'(rom_addr), 32'h002);
        step();
        expect_valid("s2_st1", 10'h002, 9'h0A7, 16'd2);
        chk("s2_st1_rom_addr", 32'(rom_addr), 32'h002);
        step();
        expect_valid("s2_st2", 10'h002, 9'h0A7, 16'd2);
        chk("s2_st2_rom_addr", 32'(rom_addr), 32'h002);
        step();
        stall = 1'b0;
        #1;
        expect_valid("s2_rel", 10'h002, 9'h0A7, 16'd2);
        step(); expect_valid("s2_p3", 10'h003, 9'h0A6, 16'd3);
        step();

        // Scenario 3: redirect to 0x155 at pc 4
        absjump_en = 1'b1;
        target     = 10'h155;
        #1;
        expect_valid("s3_p4", 10'h004, 9'h0A1, 16'd4);
        step();
        absjump_en = 1'b0;
        #1;
        expect_bubble("s3_bub", 10'h155, 16'd5);
        step(); expect_valid("s3_t0", 10'h155, 9'h1F0, 16'd5);
        step(); expect_valid("s3_t1", 10'h156, 9'h1F3, 16'd6);

        // Scenario 4: redirect to the top address, wrap without bubble
        absjump_en = 1'b1;
        target     = 10'h3FF;
        step();
        absjump_en = 1'b0;
        #1;
        expect_bubble("s4_bub", 10'h3FF, 16'd7);
        step(); expect_valid("s4_top",  10'h3FF, 9'h15A, 16'd7);
        step(); expect_valid("s4_w0",   10'h000, 9'h0A5, 16'd8);
        step(); expect_valid("s4_w1",   10'h001, 9'h0A4, 16'd9);
        step(); expect_valid("s4_w2",   10'h002, 9'h0A7, 16'd10);
        step(); expect_valid("s4_w3",   10'h003, 9'h0A6, 16'd11);
        step(); expect_valid("s4_w4",   10'h004, 9'h0A1, 16'd12);
        step(); expect_valid("s4_w5",   10'h005, 9'h0A0, 16'd13);

        // Scenario 6: asynchronous reset mid-cycle while stalled at pc 5
        stall = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("s6_valid", 32'(instr_valid), 32'd0);
        chk("s6_done",  32'(done),        32'd0);
        chk("s6_count", 32'(instr_count), 32'd0);
        chk("s6_pc",    32'(prog_ctr),    32'd0);
        chk("s6_instr", 32'(instr),       32'd0);
        $display("step s6_rst: valid=%0b pc=%h count=%0d done=%0b",
                 instr_valid, prog_ctr, instr_count, done);
        mem[6] = 9'h1FF;
        stall  = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        expect_bubble("s6_c0", 10'h000, 16'd0);
        step(); expect_valid("s6_p0", 10'h000, 9'h0A5, 16'd0);
        step(); expect_valid("s6_p1", 10'h001, 9'h0A4, 16'd1);
        step(); expect_valid("s6_p2", 10'h002, 9'h0A7, 16'd2);
        step(); expect_valid("s6_p3", 10'h003, 9'h0A6, 16'd3);
        step(); expect_valid("s6_p4", 10'h004, 9'h0A1, 16'd4);
        step(); expect_valid("s6_p5", 10'h005, 9'h0A0, 16'd5);

        // Scenario 5: halt at pc 6 with a simultaneous redirect request
        step();
        absjump_en = 1'b1;
        target     = 10'h020;
        #1;
        expect_valid("s5_p6", 10'h006, 9'h1FF, 16'd6);
        step();
        chk("s5_done", 32'(done), 32'd1);
        expect_bubble("s5_halt", 10'h007, 16'd7);
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("s5_hold%0d_done", c), 32'(done), 32'd1);
            expect_bubble($sformatf("s5_hold%0d", c), 10'h007, 16'd7);
        end
        absjump_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
